// File: rtl/custom_ip_reg_arbiter.sv
// Round-robin arbiter granting NREQ requesters single-transaction access to a
// small register bank; one transaction in flight, read wait bounded to 16 cycles.
//
//   state  | meaning
//   IDLE   | arbitrating; req_ready_o asserted for the round-robin winner
//   EXEC   | performing the latched write strobe or waiting for read data
//   RESP   | presenting the response to the owner until it is accepted
module custom_ip_reg_arbiter #(
  parameter int NREQ = 2,
  parameter int NREG = 3,
  parameter int DW   = 32,
  parameter int AW   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0]      req_we_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_wdata_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [DW-1:0]        rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic [NREG-1:0]      reg_we_o,
  output logic [DW-1:0]        reg_wdata_o,
  input  logic [NREG*DW-1:0]   reg_rdata_i,
  input  logic [NREG-1:0]      reg_rvalid_i,
  output logic                 busy_o
);

  localparam int          IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d;
  logic            we_q, we_d, err_q, err_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            win_found, win_we, sel_rvalid, addr_ok, read_timeout;
  logic [IDW-1:0]  win_id;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata, sel_rdata;
  int              k;

  // First valid requester at or after ptr, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    k         = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr_q) + i) % NREQ;
      if (!win_found && req_valid_i[k]) begin
        win_found = 1'b1;
        win_id    = k[IDW-1:0];
        win_we    = req_we_i[k];
        win_addr  = req_addr_i[k*AW +: AW];
        win_wdata = req_wdata_i[k*DW +: DW];
      end
    end
  end

  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int r = 0; r < NREG; r++) begin
      if ({1'b0, addr_q} == (AW+1)'(r)) begin
        sel_rvalid = reg_rvalid_i[r];
        sel_rdata  = reg_rdata_i[r*DW +: DW];
      end
    end
  end

  assign addr_ok      = ({1'b0, addr_q} < NREG_W);
  assign read_timeout = (cnt_q == 4'hF);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (win_found) state_d = S_EXEC;
      S_EXEC: if (!addr_ok || we_q || sel_rvalid || read_timeout) state_d = S_RESP;
      S_RESP: if (rsp_ready_i[id_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          id_d    = win_id;
          we_d    = win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          cnt_d   = '0;
        end
      end
      S_EXEC: begin
        if (!addr_ok) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (we_q) begin
          err_d = 1'b0;
        end else if (sel_rvalid) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
        end else if (read_timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i[id_q]) begin
          if (int'(id_q) == NREQ - 1) ptr_d = '0;
          else                        ptr_d = id_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs are gated by rst_i so a reset cycle never strobes.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    reg_we_o    = '0;
    if (!rst_i) begin
      if (state_q == S_IDLE && win_found) req_ready_o[win_id] = 1'b1;
      if (state_q == S_RESP)              rsp_valid_o[id_q]   = 1'b1;
      if (state_q == S_EXEC && we_q) begin
        for (int r = 0; r < NREG; r++) begin
          if ({1'b0, addr_q} == (AW+1)'(r)) reg_we_o[r] = 1'b1;
        end
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: doc/custom_ip_reg_arbiter.md
CUSTOM_IP_REG_ARBITER -- requirements
Module: custom_ip_reg_arbiter

Interface
REQ-001 The block SHALL have one clock, clk_i, and a synchronous active-high reset, rst_i, sampled only on the rising edge of clk_i.
REQ-002 Parameter NREQ, default 2: number of requester ports.
REQ-003 Parameter NREG, default 3: number of registers in the IP register bank.
REQ-004 Parameter DW, default 32: data width.
REQ-005 Parameter AW, default 2: address width; the SHALL constraint is 2**AW >= NREG.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  synchronous reset, active high.
REQ-008 req_valid_i  in  NREQ  per-requester request valid.
REQ-009 req_ready_o  out  NREQ  per-requester request accept.
REQ-010 req_we_i  in  NREQ  per-requester direction: 1 = write, 0 = read.
REQ-011 req_addr_i  in  NREQ*AW  per-requester register index; requester k occupies bits [k*AW +: AW].
REQ-012 req_wdata_i  in  NREQ*DW  per-requester write data.
REQ-013 rsp_valid_o  out  NREQ  per-requester response valid.
REQ-014 rsp_ready_i  in  NREQ  per-requester response accept.
REQ-015 rsp_rdata_o  out  DW  read data, shared by all requesters and qualified by rsp_valid_o.
REQ-016 rsp_err_o  out  1  error flag, qualified by rsp_valid_o.
REQ-017 reg_we_o  out  NREG  one-hot, single-cycle write strobe to the register bank.
REQ-018 reg_wdata_o  out  DW  write data to the register bank.
REQ-019 reg_rdata_i  in  NREG*DW  register bank read data; register r occupies bits [r*DW +: DW].
REQ-020 reg_rvalid_i  in  NREG  per-register read-data-ready flag from the bank.
REQ-021 busy_o  out  1  high whenever the FSM is in any state other than IDLE.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-023 In IDLE, the winner SHALL be the first requester with req_valid_i set, searching from ptr upward and wrapping at NREQ.
  - req_ready_o SHALL be high for the winner only, combinationally, and only in IDLE.
REQ-024 On the req handshake, the block SHALL latch the winner's id, we, addr and wdata, then move IDLE->EXEC.
REQ-025 EXEC, addr >= NREG:
  - no reg_we_o strobe;
  - set err=1 and rdata=0;
  - move to RESP.
REQ-026 EXEC, write:
  - reg_we_o[addr]=1 for exactly one cycle;
  - reg_wdata_o = latched wdata;
  - set err=0 and move to RESP.
REQ-027 EXEC, read: wait until reg_rvalid_i[addr]=1, then capture reg_rdata_i[addr], set err=0 and move to RESP.
REQ-028 EXEC, read timeout: a 4-bit wait counter SHALL count cycles spent in EXEC.
  - If reg_rvalid_i[addr] is still low after 16 cycles, set err=1 and rdata=0, then move to RESP.
  - The counter SHALL clear on entry to EXEC.
REQ-029 RESP:
  - rsp_valid_o[id]=1 and all other rsp_valid_o bits 0;
  - rsp_rdata_o and rsp_err_o SHALL be held stable until rsp_ready_i[id]=1;
  - on that handshake, ptr <= (id+1) mod NREQ and the FSM returns to IDLE.
REQ-030 rsp_ready_i bits for requesters other than id SHALL be ignored.
REQ-031 Latency for a write with the handshake at edge T:
  - reg_we_o is high in cycle T+1;
  - rsp_valid_o is high from cycle T+2.
REQ-032 Latency for a read with reg_rvalid_i already high: rdata is captured at T+1 and rsp_valid_o is high from T+2.
REQ-033 The block SHALL allow one outstanding transaction only; req_ready_o SHALL be all-zero outside IDLE.
REQ-034 The block SHALL NOT accept a new request in the same cycle as a response handshake; the earliest new acceptance is the next cycle.
REQ-035 Requests arriving while busy_o=1 SHALL be held by the requester and SHALL NOT be dropped or reordered by the block.
REQ-036 A requester that deasserts req_valid_i before its handshake SHALL simply lose arbitration, with no side effect.
REQ-037 reg_wdata_o SHALL hold the last latched wdata when no strobe is active.

Reset
REQ-038 While rst_i is high, reg_we_o, rsp_valid_o and req_ready_o SHALL be forced to 0 combinationally, so that no strobe or handshake occurs in a reset cycle.
REQ-039 The first rising edge with rst_i high SHALL set the following values:
  - state=IDLE, ptr=0, wait counter=0;
  - latched id, addr and wdata = 0;
  - rsp_rdata_o=0, rsp_err_o=0, reg_wdata_o=0, busy_o=0.
REQ-040 A reset asserted in EXEC or RESP SHALL abandon the transaction: no strobe and no response SHALL be issued afterwards.

Verification
REQ-041 Requester 0 writes addr=1, wdata=0xDEADBEEF -> reg_we_o=3'b010 for one cycle at T+1 with reg_wdata_o=0xDEADBEEF; rsp_valid_o[0] at T+2 with err=0.
REQ-042 Both requesters are valid continuously, all writes, ptr=0 after reset -> grants alternate 0,1,0,1; each rsp_valid_o bit goes only to the granted requester.
REQ-043 Requester 1 reads addr=2 with reg_rvalid_i[2]=0 for 5 cycles and then 1, with reg_rdata_i[2]=0x12345678 -> rsp_rdata_o=0x12345678, err=0, exactly one read response.
REQ-044 Read of addr=0 with reg_rvalid_i[0] stuck at 0 -> rsp_valid_o after 16 EXEC cycles with err=1 and rdata=0.
REQ-045 Write to addr=3 (out of range, NREG=3) -> no reg_we_o bit ever set; response err=1.
REQ-046 Scenario: rsp_ready_i held low for 10 cycles -> response stable with no new grant; then rst_i asserted in RESP -> rsp_valid_o=0, busy_o=0, and the next request is granted from ptr=0.
